// File: rtl/mux_sel_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_scan_pkg : shared types and select ordering for mux_sel_scanner  |
// | Option macro SCAN_GRAY_EN selects Gray select order. Rev 1.0         |
// +----------------------------------------------------------------------+
package mux_scan_pkg;

    typedef logic [1:0] sel_t;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

`ifdef SCAN_GRAY_EN
    localparam sel_t LAST_SEL = 2'd2;
`else
    localparam sel_t LAST_SEL = 2'd3;
`endif

    function automatic sel_t next_sel(input sel_t cur);
`ifdef SCAN_GRAY_EN
        sel_t nxt;
        case (cur)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd3;
            2'd3:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
`else
        return cur + 2'd1;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_scanner_step_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_debounce : 2-FF sync, counter debounce and press pulse for key  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module step_debounce #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_n_i,
    output logic press_o
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= step_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any sample matching the current level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/mux_sel_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_sel_scanner : drives 4:1 mux select, samples z into captured[]   |
// | Option macro SCAN_GRAY_EN selects Gray select order. Rev 1.0         |
// +----------------------------------------------------------------------+
module mux_sel_scanner
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned DEB_CYCLES   = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       step_n,
    input  logic       z,
    output logic [1:0] s,
    output logic [3:0] captured,
    output logic       sample_valid,
    output logic       frame_done
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    logic          press;
    logic          mode_meta_q;
    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    sel_t          s_q;
    logic [3:0]    cap_q;
    logic          sv_q;
    logic          fd_q;
    logic          take;

    step_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_n_i (step_n),
        .press_o  (press)
    );

    // The state register is the second synchroniser stage for mode.
    always_comb begin
        state_d = mode_meta_q ? SCAN : MANUAL;
        take    = 1'b0;
        dwell_d = '0;
        if (state_q == SCAN) begin
            take    = (dwell_q == DWELL_LAST);
            dwell_d = take ? '0 : dwell_q + DW'(1);
        end else begin
            take = press;
        end
        if (state_d != state_q) begin
            dwell_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta_q <= 1'b0;
            state_q     <= MANUAL;
            dwell_q     <= '0;
            s_q         <= '0;
            cap_q       <= '0;
            sv_q        <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            mode_meta_q <= mode;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            sv_q        <= take;
            fd_q        <= take && (s_q == LAST_SEL);
            if (take) begin
                cap_q[s_q] <= z;
                s_q        <= next_sel(s_q);
            end
        end
    end

    assign s            = s_q;
    assign captured     = cap_q;
    assign sample_valid = sv_q;
    assign frame_done   = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux_sel_scanner : scoreboard bench for mux_sel_scanner            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mux_sel_scanner;

    localparam int DWELL = 4;
    localparam int DEB   = 3;
`ifdef SCAN_GRAY_EN
    localparam logic [1:0] LAST = 2'd2;
`else
    localparam logic [1:0] LAST = 2'd3;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       mode   = 1'b0;
    logic       step_n = 1'b1;
    logic       z;
    logic [1:0] s;
    logic [3:0] captured;
    logic       sample_valid;
    logic       frame_done;

    logic z_sel = 1'b1;
    logic z_val = 1'b0;
    assign z = z_sel ? s[0] : z_val;

    mux_sel_scanner #(
        .DWELL_CYCLES(DWELL),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .step_n       (step_n),
        .z            (z),
        .s            (s),
        .captured     (captured),
        .sample_valid (sample_valid),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] s;
        logic [3:0] cap;
        logic       fd;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [1:0] exp_s   = 2'd0;
    logic [3:0] exp_cap = 4'd0;
    logic [1:0] prev_s  = 2'd0;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [1:0] model_next(input logic [1:0] c);
`ifdef SCAN_GRAY_EN
        case (c)
            2'd0:    return 2'd1;
            2'd1:    return 2'd3;
            2'd3:    return 2'd2;
            default: return 2'd0;
        endcase
`else
        return c + 2'd1;
`endif
    endfunction

    function void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Model one sample: channel exp_s takes the z the mux would present.
    function void push_sample(input int c);
        exp_t e;
        logic zz;
        zz = z_sel ? exp_s[0] : z_val;
        exp_cap[exp_s] = zz;
        e.fd  = (exp_s == LAST);
        exp_s = model_next(exp_s);
        e.cyc = c;
        e.s   = exp_s;
        e.cap = exp_cap;
        q.push_back(e);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press();
        int t;
        t = cyc;
        step_n = 1'b0;
        push_sample(t + 6);
        wait_until(t + 9);
        step_n = 1'b1;
        wait_until(t + 16);
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_done && !sample_valid)
            chk("fd_without_sv", 1, 0);
        if (rst_n && sample_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("sample_cycle", cyc, mon_e.cyc);
                chk("sample_s", s, mon_e.s);
                chk("sample_captured", captured, mon_e.cap);
                chk("sample_frame_done", frame_done, mon_e.fd);
            end
`ifdef SCAN_GRAY_EN
            chk("gray_one_bit", $countones(s ^ prev_s), 1);
`endif
        end
        prev_s = s;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t, t2, tr;
        repeat (3) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_captured", captured, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Auto scan, with a key press inside the scan that must be ignored.
        z_sel = 1'b1;
        t0 = cyc;
        mode = 1'b1;
        for (int k = 0; k < 5; k++) push_sample(t0 + 6 + 4 * k);
        wait_until(t0 + 8);
        step_n = 1'b0;
        wait_until(t0 + 16);
        step_n = 1'b1;
        wait_until(t0 + 23);
        mode = 1'b0;
        wait_until(t0 + 32);
        chk("scan_frame_captured", captured, 4'b1010);
        chk("mode_drop_s_held", s, exp_s);
        chk("mode_drop_cap_held", captured, exp_cap);

        // Re-entering SCAN must start a fresh dwell.
        t1 = cyc;
        mode = 1'b1;
        push_sample(t1 + 6);
        wait_until(t1 + 7);
        mode = 1'b0;
        wait_until(t1 + 14);
        chk("reentry_s", s, exp_s);

        // Bouncy press in MANUAL: one sample 6 cycles after the stable low.
        z_sel = 1'b0;
        z_val = 1'b1;
        t = cyc;
        step_n = 1'b0;
        @(negedge clk) step_n = 1'b1;
        @(negedge clk) step_n = 1'b0;
        @(negedge clk) step_n = 1'b1;
        @(negedge clk) step_n = 1'b0;
        push_sample(t + 10);
        wait_until(t + 13);
        step_n = 1'b1;
        wait_until(t + 22);
        chk("bounce_captured", captured, exp_cap);

        // Manual wrap: bring s to 0 then four presses with z=1.
        for (int i = 0; i < 3 && exp_s != 2'd0; i++) press();
        for (int i = 0; i < 4; i++) press();
        chk("wrap_captured", captured, 4'b1111);
        chk("wrap_s", s, 0);

        // Reset in the middle of a dwell on the third visited channel.
        z_sel = 1'b1;
        t2 = cyc;
        mode = 1'b1;
        push_sample(t2 + 6);
        push_sample(t2 + 10);
        wait_until(t2 + 12);
        rst_n = 1'b0;
        #1;
        chk("midrst_s", s, 0);
        chk("midrst_captured", captured, 0);
        chk("midrst_sample_valid", sample_valid, 0);
        chk("midrst_frame_done", frame_done, 0);
        exp_s   = 2'd0;
        exp_cap = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tr = cyc;
        for (int k = 0; k < 4; k++) push_sample(tr + 6 + 4 * k);
        wait_until(tr + 19);
        mode = 1'b0;
        wait_until(tr + 26);
        chk("post_reset_captured", captured, 4'b1010);

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("final_s", s, exp_s);
        chk("final_captured", captured, exp_cap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
